// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, default bit timing and
// frame-length helper used by the transmitter, receiver and scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        SCH_IDLE   = 2'd0,
        SCH_LAUNCH = 2'd1,
        SCH_WAIT   = 2'd2
    } sch_state_t;

    localparam int unsigned BR_CLOCK_CYCLES = 20;
    localparam int unsigned FRAME_BITS      = 11;

    function automatic int unsigned frame_cycles(input int unsigned br_cycles,
                                                 input int unsigned bits,
                                                 input int unsigned guard);
        return br_cycles * bits + guard;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above
// i_rr_ptr, wrapping around, wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDW-1:0]     o_grant_idx,
    output logic               o_any
);

    int unsigned        v_idx;
    logic [NUM_REQ-1:0] v_sh;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        v_idx       = 0;
        v_sh        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            v_idx = 32'(i_rr_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            v_sh = i_req >> v_idx;
            if (!o_any && v_sh[0]) begin
                o_any       = 1'b1;
                o_grant     = NUM_REQ'(1) << v_idx;
                o_grant_idx = IDW'(v_idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// producers; frames are timed internally since the transmitter has no busy flag.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned BR_CLOCK_CYCLES = uart_pkg::BR_CLOCK_CYCLES,
    parameter int unsigned FRAME_BITS      = uart_pkg::FRAME_BITS,
    parameter int unsigned GUARD_CYCLES    = 2,
    parameter int unsigned CNT_WIDTH       = 16,
    localparam int unsigned IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sched_en,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy,
    output logic                   frame_done
);

    import uart_pkg::*;

    localparam int unsigned          FRAME_CYCLES = frame_cycles(BR_CLOCK_CYCLES, FRAME_BITS, GUARD_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TIMER_LOAD   = CNT_WIDTH'(FRAME_CYCLES - 1);

    if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_scheduler: NUM_REQ must be in 1..8");
    end
    if (64'(FRAME_CYCLES) >= (64'd1 << CNT_WIDTH)) begin : g_bad_cnt_width
        $error("uart_tx_scheduler: CNT_WIDTH too narrow for FRAME_CYCLES");
    end

    sch_state_t           r_state;
    sch_state_t           w_state_next;
    logic [IDW-1:0]       r_rr_ptr;
    logic [IDW-1:0]       w_win_idx;
    logic [NUM_REQ-1:0]   w_win_grant;
    logic                 w_any;
    logic                 w_accept;
    logic                 w_frame_end;
    logic [NUM_REQ-1:0]   w_ready;
    logic [8*NUM_REQ-1:0] w_sel;
    logic [CNT_WIDTH-1:0] r_timer;
    logic                 r_tx_en;
    logic [7:0]           r_tx_data;
    logic [IDW-1:0]       r_grant_id;
    logic                 r_busy;
    logic                 r_frame_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .i_req       (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_win_grant),
        .o_grant_idx (w_win_idx),
        .o_any       (w_any)
    );

    assign w_sel = req_data >> {w_win_idx, 3'b000};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= SCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_ready      = '0;
        w_frame_end  = 1'b0;
        case (r_state)
            SCH_IDLE: begin
                if (sched_en && w_any) begin
                    w_accept     = 1'b1;
                    w_ready      = w_win_grant;
                    w_state_next = SCH_LAUNCH;
                end
            end
            SCH_LAUNCH: begin
                w_state_next = SCH_WAIT;
            end
            SCH_WAIT: begin
                if (r_timer == '0) begin
                    w_frame_end  = 1'b1;
                    w_state_next = SCH_IDLE;
                end
            end
            default: begin
                w_state_next = SCH_IDLE;
            end
        endcase
    end

    // Timer is loaded on the accept edge so it already reads FRAME_CYCLES-1
    // during LAUNCH; counting through LAUNCH and WAIT frees IDLE at A+1+FRAME_CYCLES.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_en      <= 1'b0;
            r_tx_data    <= '0;
            r_grant_id   <= '0;
            r_rr_ptr     <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_timer      <= '0;
        end else begin
            r_tx_en      <= w_accept;
            r_frame_done <= w_frame_end;
            if (w_accept) begin
                r_tx_data  <= w_sel[7:0];
                r_grant_id <= w_win_idx;
                r_rr_ptr   <= (w_win_idx == IDW'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
                r_busy     <= 1'b1;
                r_timer    <= TIMER_LOAD;
            end else begin
                if (r_state != SCH_IDLE && r_timer != '0) begin
                    r_timer <= r_timer - 1'b1;
                end
                if (w_frame_end) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign req_ready  = w_ready;
    assign tx_en      = r_tx_en;
    assign tx_data    = r_tx_data;
    assign grant_id   = r_grant_id;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus random
// traffic compared cycle by cycle against a transaction-timeline model.
module tb_uart_tx_scheduler;

    localparam int NREQ = 4;
    localparam int FC   = 20 * 11 + 2;

    logic        clock     = 1'b0;
    logic        reset     = 1'b0;
    logic        sched_en  = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_ready;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        frame_done;

    always #5 clock = ~clock;

    uart_tx_scheduler #(
        .NUM_REQ         (4),
        .BR_CLOCK_CYCLES (20),
        .FRAME_BITS      (11),
        .GUARD_CYCLES    (2),
        .CNT_WIDTH       (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sched_en   (sched_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .grant_id   (grant_id),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: the last accept cycle fixes every timed output of the frame.
    int         acc_cyc;
    int         ptr;
    logic [7:0] m_data;
    int         m_gid;
    int         grant_log[$];
    int         txen_log[$];
    int         done_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick_winner(input logic [3:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (p + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        acc_cyc = -1000;
        ptr     = 0;
        m_data  = '0;
        m_gid   = 0;
    endtask

    task automatic step();
        int         w;
        logic [3:0] exp_ready;
        @(negedge clock);
        exp_ready = '0;
        w         = -1;
        if (cyc >= acc_cyc + FC + 1 && sched_en) begin
            w = pick_winner(req_valid, ptr);
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        check("req_ready",  32'(req_ready),  32'(exp_ready));
        check("tx_en",      32'(tx_en),      32'(cyc == acc_cyc + 1));
        check("tx_data",    32'(tx_data),    32'(m_data));
        check("grant_id",   32'(grant_id),   32'(m_gid));
        check("busy",       32'(busy),       32'(cyc > acc_cyc && cyc < acc_cyc + FC + 1));
        check("frame_done", 32'(frame_done), 32'(cyc == acc_cyc + FC + 1));
        if (tx_en === 1'b1) txen_log.push_back(cyc);
        if (frame_done === 1'b1) done_log.push_back(cyc);
        if (w >= 0) begin
            acc_cyc = cyc;
            m_data  = req_data[8*w +: 8];
            m_gid   = w;
            ptr     = (w + 1) % NREQ;
            grant_log.push_back(w);
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_accept(input string tag);
        int n0;
        int k;
        n0 = grant_log.size();
        k  = 0;
        while (grant_log.size() == n0 && k < 600) begin
            step();
            k++;
        end
        check({tag, "_accept"}, 32'(grant_log.size() > n0), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  32'(req_ready),  32'd0);
        check({tag, "_tx_en"},  32'(tx_en),      32'd0);
        check({tag, "_data"},   32'(tx_data),    32'd0);
        check({tag, "_gid"},    32'(grant_id),   32'd0);
        check({tag, "_busy"},   32'(busy),       32'd0);
        check({tag, "_done"},   32'(frame_done), 32'd0);
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int n0;
        int t0;

        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("rst");
        reset = 1'b1;

        // Single requester
        sched_en       = 1'b1;
        req_valid      = 4'b0001;
        req_data[7:0]  = 8'hA5;
        t0             = txen_log.size();
        n0             = done_log.size();
        step();
        req_valid = '0;
        req_data  = 32'hDEADBEEF;
        run(230);
        check("single_launch_cnt", 32'(txen_log.size() - t0), 32'd1);
        check("single_done_cnt",   32'(done_log.size() - n0), 32'd1);
        if (txen_log.size() > t0 && done_log.size() > n0)
            check("single_done_delay", 32'(done_log[n0] - txen_log[t0]), 32'd222);

        // Contention from a fresh pointer
        do_reset();
        grant_log.delete();
        t0        = txen_log.size();
        req_data  = 32'h43322110;
        req_valid = 4'b1111;
        run(5 * FC + 10);
        req_valid = '0;
        check("contention_grants", 32'(grant_log.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check("contention_order", 32'(grant_log[i]), 32'(i % NREQ));
        for (int i = t0 + 1; i < txen_log.size(); i++)
            check("txen_spacing", 32'(txen_log[i] - txen_log[i-1]), 32'(FC + 1));

        // Wrap: last grant 2, then 0 and 3 compete
        req_valid = 4'b0100;
        wait_accept("wrap_g2");
        check("wrap_first", 32'(grant_log[$]), 32'd2);
        req_valid = 4'b1001;
        wait_accept("wrap_g3");
        check("wrap_second", 32'(grant_log[$]), 32'd3);

        // Valid pulsed for one cycle while busy is never accepted
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        n0 = grant_log.size();
        run(FC + 10);
        check("withdrawn_no_accept", 32'(grant_log.size()), 32'(n0));

        // sched_en dropped mid-WAIT, frame still completes
        req_valid = 4'b0010;
        wait_accept("en_first");
        run(50);
        sched_en = 1'b0;
        n0 = done_log.size();
        t0 = grant_log.size();
        run(FC);
        check("en_off_done",     32'(done_log.size() - n0), 32'd1);
        check("en_off_noaccept", 32'(grant_log.size()), 32'(t0));
        sched_en = 1'b1;
        step();
        check("en_on_same_cycle", 32'(grant_log.size()), 32'(t0 + 1));
        req_valid = '0;

        // Asynchronous reset 50 clocks into WAIT
        run(52);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        check("post_reset_gid", 32'(grant_log[$]), 32'd1);
        run(FC + 5);

        // Random traffic
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom);
            if ($urandom_range(0, 1) == 0) req_data = $urandom;
            sched_en = ($urandom_range(0, 15) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
